// File: rtl/pin_sequencer.sv
// Bus master that turns host commands into per-pin register-write bursts, sample reads and global writes.
// Optional PIN_SEQ_AUTO_ARM_EN appends a global-start write (addr 0, data 1) to every OUTPUT burst.
module pin_sequencer #(
    parameter int          NUM_PINS   = 16,
    parameter int          PIN_STRIDE = 8,
    parameter int          READ_LAT   = 2,
    parameter logic [20:0] PARK_ADDR  = 21'h1FFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_pin,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [15:0] cmd_c,
    input  logic        cmd_inf,
    output logic [20:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_PARK, S_RD_WAIT, S_RSP} state_t;

    localparam logic [1:0] OP_OUTPUT  = 2'd0;
    localparam logic [1:0] OP_CAPTURE = 2'd1;
    localparam logic [1:0] OP_READ    = 2'd2;
    localparam logic [1:0] OP_GLOBAL  = 2'd3;
    localparam logic [2:0] LAT_INIT   = 3'(READ_LAT - 1);
`ifdef PIN_SEQ_AUTO_ARM_EN
    localparam logic [2:0] OUT_LAST   = 3'd5;
`else
    localparam logic [2:0] OUT_LAST   = 3'd4;
`endif

    if (NUM_PINS * PIN_STRIDE >= int'(PARK_ADDR)) begin : g_bad_map
        $error("pin_sequencer: pin address map reaches PARK_ADDR");
    end
    if (READ_LAT < 1 || READ_LAT > 7) begin : g_bad_lat
        $error("pin_sequencer: READ_LAT must be 1..7");
    end

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [2:0]  lat_q, lat_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  pin_q, pin_d;
    logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic        inf_q, inf_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic [20:0] base;
    logic [20:0] wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  last_step;
    logic        pin_ok;

    assign base   = 21'(pin_q) * 21'(PIN_STRIDE);
    assign pin_ok = int'(cmd_pin) < NUM_PINS;

    // Burst table: register address and data for the current step of the latched op.
    always_comb begin
        wr_addr   = 21'd0;
        wr_data   = a_q;
        last_step = 3'd0;
        case (op_q)
            OP_OUTPUT: begin
                last_step = OUT_LAST;
                case (step_q)
                    3'd0:    begin wr_addr = base + 21'd1; wr_data = a_q;            end
                    3'd1:    begin wr_addr = base + 21'd2; wr_data = b_q;            end
                    3'd2:    begin wr_addr = base + 21'd3; wr_data = c_q;            end
                    3'd3:    begin wr_addr = base + 21'd4; wr_data = {15'd0, inf_q}; end
                    3'd4:    begin wr_addr = base + 21'd5; wr_data = 16'd4;          end
                    default: begin wr_addr = 21'd0;        wr_data = 16'd1;          end
                endcase
            end
            OP_CAPTURE: begin
                last_step = 3'd1;
                if (step_q == 3'd0) begin
                    wr_addr = base + 21'd6;
                    wr_data = a_q;
                end else begin
                    wr_addr = base + 21'd5;
                    wr_data = 16'd3;
                end
            end
            default: ;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        lat_d      = lat_q;
        op_d       = op_q;
        pin_d      = pin_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        inf_d      = inf_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        rsp_valid  = 1'b0;
        bus_addr   = PARK_ADDR;
        bus_wdata  = 16'd0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    pin_d  = cmd_pin;
                    a_d    = cmd_a;
                    b_d    = cmd_b;
                    c_d    = cmd_c;
                    inf_d  = cmd_inf;
                    step_d = 3'd0;
                    lat_d  = LAT_INIT;
                    if (cmd_op != OP_GLOBAL && !pin_ok) begin
                        rsp_data_d = 16'd0;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RSP;
                    end else if (cmd_op == OP_READ) begin
                        rsp_err_d = 1'b0;
                        state_d   = S_RD_WAIT;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                bus_addr  = wr_addr;
                bus_wdata = wr_data;
                step_d    = step_q + 3'd1;
                if (step_q == last_step) state_d = S_PARK;
            end
            S_PARK: begin
                state_d = (op_q == OP_READ) ? S_RSP : S_IDLE;
            end
            S_RD_WAIT: begin
                bus_addr = base + 21'd7;
                if (lat_q == 3'd0) begin
                    rsp_data_d = bus_rdata;
                    state_d    = S_PARK;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_q     <= 3'd0;
            lat_q      <= 3'd0;
            op_q       <= 2'd0;
            pin_q      <= 8'd0;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            c_q        <= 16'd0;
            inf_q      <= 1'b0;
            rsp_data_q <= 16'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            lat_q      <= lat_d;
            op_q       <= op_d;
            pin_q      <= pin_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            inf_q      <= inf_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_pin_sequencer.sv
// Self-checking bench for pin_sequencer: directed cases plus random commands checked against a
// command-level model that derives the expected bus trace and response from the register map.
module tb_pin_sequencer;

    localparam int          NUM_PINS   = 16;
    localparam int          PIN_STRIDE = 8;
    localparam int          READ_LAT   = 2;
    localparam logic [20:0] PARK       = 21'h1FFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_pin = 8'd0;
    logic [15:0] cmd_a = 16'd0, cmd_b = 16'd0, cmd_c = 16'd0;
    logic        cmd_inf = 1'b0;
    logic [20:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    pin_sequencer #(
        .NUM_PINS(NUM_PINS), .PIN_STRIDE(PIN_STRIDE), .READ_LAT(READ_LAT), .PARK_ADDR(PARK)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pin(cmd_pin),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_inf(cmd_inf),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scramble_cmd();
        cmd_op  = 2'($urandom);
        cmd_pin = 8'($urandom);
        cmd_a   = 16'($urandom);
        cmd_b   = 16'($urandom);
        cmd_c   = 16'($urandom);
        cmd_inf = 1'($urandom);
    endtask

    // Issues one command and checks the whole resulting bus trace and response.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] pin, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] c, input logic inf,
                          input logic [15:0] rd_val, input int hold);
        logic [20:0] base;
        logic [20:0] ea[$];
        logic [15:0] ed[$];
        bit          bad;
        int          n;
        base = 21'(pin) * 21'(PIN_STRIDE);
        bad  = (op != 2'd3) && (int'(pin) >= NUM_PINS);
        if (!bad) begin
            case (op)
                2'd0: begin
                    ea.push_back(base + 21'd1); ed.push_back(a);
                    ea.push_back(base + 21'd2); ed.push_back(b);
                    ea.push_back(base + 21'd3); ed.push_back(c);
                    ea.push_back(base + 21'd4); ed.push_back({15'd0, inf});
                    ea.push_back(base + 21'd5); ed.push_back(16'd4);
`ifdef PIN_SEQ_AUTO_ARM_EN
                    ea.push_back(21'd0); ed.push_back(16'd1);
`endif
                end
                2'd1: begin
                    ea.push_back(base + 21'd6); ed.push_back(a);
                    ea.push_back(base + 21'd5); ed.push_back(16'd3);
                end
                2'd3: begin
                    ea.push_back(21'd0); ed.push_back(a);
                end
                default: ;
            endcase
        end

        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
            return;
        end

        cmd_op = op; cmd_pin = pin; cmd_a = a; cmd_b = b; cmd_c = c; cmd_inf = inf;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        scramble_cmd();

        if (bad) begin
            @(negedge clk);
            check("bad_addr", bus_addr, PARK);
            check("bad_rsp_valid", rsp_valid, 1);
            check("bad_rsp_err", rsp_err, 1);
            check("bad_rsp_data", rsp_data, 0);
        end else if (op == 2'd2) begin
            for (int k = 1; k <= READ_LAT; k++) begin
                bus_rdata = (k == READ_LAT) ? rd_val : 16'($urandom);
                @(negedge clk);
                check("rd_addr", bus_addr, base + 21'd7);
                check("rd_wdata", bus_wdata, 0);
                check("rd_rsp_early", rsp_valid, 0);
                @(posedge clk);
                #1;
            end
            bus_rdata = 16'($urandom);
            @(negedge clk);
            check("rd_park", bus_addr, PARK);
            check("rd_park_valid", rsp_valid, 0);
            @(negedge clk);
            check("rd_rsp_valid", rsp_valid, 1);
            check("rd_rsp_data", rsp_data, rd_val);
            check("rd_rsp_err", rsp_err, 0);
        end else begin
            foreach (ea[i]) begin
                @(negedge clk);
                check("wr_addr", bus_addr, ea[i]);
                check("wr_data", bus_wdata, ed[i]);
                check("wr_ready", cmd_ready, 0);
            end
            @(negedge clk);
            check("wr_park_addr", bus_addr, PARK);
            check("wr_park_data", bus_wdata, 0);
            check("wr_park_busy", busy, 1);
            @(negedge clk);
            check("wr_idle_ready", cmd_ready, 1);
            check("wr_idle_busy", busy, 0);
            check("wr_idle_rsp", rsp_valid, 0);
        end

        if (bad || op == 2'd2) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", rsp_valid, 1);
                check("hold_data", rsp_data, bad ? 16'd0 : rd_val);
                check("hold_err", rsp_err, bad ? 1 : 0);
                check("hold_ready", cmd_ready, 0);
                check("hold_addr", bus_addr, PARK);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            check("rsp_done_valid", rsp_valid, 0);
            check("rsp_done_ready", cmd_ready, 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_addr", bus_addr, PARK);
        check("rst_wdata", bus_wdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        reset = 1'b0;
        @(negedge clk);

        do_cmd(2'd0, 8'd2, 16'd10, 16'd5, 16'd3, 1'b0, 16'd0, 0);
        do_cmd(2'd1, 8'd0, 16'd100, 16'd0, 16'd0, 1'b0, 16'd0, 0);
        do_cmd(2'd2, 8'd15, 16'd0, 16'd0, 16'd0, 1'b0, 16'h0001, 5);
        do_cmd(2'd2, 8'd20, 16'd0, 16'd0, 16'd0, 1'b0, 16'h1234, 2);
        do_cmd(2'd0, 8'd16, 16'd1, 16'd2, 16'd3, 1'b1, 16'd0, 0);

        // Back-to-back GLOBAL with cmd_valid held high throughout.
        cmd_op = 2'd3; cmd_pin = 8'd0; cmd_a = 16'd1; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_a = 16'd0;
        @(negedge clk);
        check("g1_addr", bus_addr, 0);
        check("g1_data", bus_wdata, 1);
        @(negedge clk);
        check("g1_park", bus_addr, PARK);
        @(negedge clk);
        check("g1_idle_ready", cmd_ready, 1);
        check("g1_idle_addr", bus_addr, PARK);
        @(negedge clk);
        check("g0_addr", bus_addr, 0);
        check("g0_data", bus_wdata, 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("g0_park", bus_addr, PARK);
        @(negedge clk);
        check("g0_idle", cmd_ready, 1);

        // Reset during the third write of an OUTPUT burst.
        cmd_op = 2'd0; cmd_pin = 8'd3; cmd_a = 16'd7; cmd_b = 16'd8; cmd_c = 16'd9; cmd_inf = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_w3", bus_addr, 21'd27);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_addr", bus_addr, PARK);
        check("rst_mid_wdata", bus_wdata, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", cmd_ready, 1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_quiet", bus_addr, PARK);
        end

        for (int i = 0; i < 60; i++) begin
            do_cmd(2'($urandom), 8'($urandom_range(0, 23)), 16'($urandom), 16'($urandom),
                   16'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
